// File: rtl/seg_scan_decoder.sv
// Recovers hex digits from a multiplexed active-low seven-segment bus.
// Each pattern is synchronized and debounced, then captured once per digit.
module seg_scan_decoder #(
  parameter int DIGITS        = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [6:0]            seg_in,
  input  logic [DIGITS-1:0]     an_in,
  output logic [4*DIGITS-1:0]   value,
  output logic [DIGITS-1:0]     digit_valid,
  output logic                  update,
  output logic                  err,
  output logic [2:0]            err_digit
);

  localparam int CW = $clog2(STABLE_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SETTLE, CAPTURED} state_t;

  // Returns {known, nibble}; known=0 for blank and undecodable patterns.
  function automatic logic [4:0] decode(input logic [6:0] p);
    case (p)
      7'h40:   decode = 5'h10;
      7'h79:   decode = 5'h11;
      7'h24:   decode = 5'h12;
      7'h30:   decode = 5'h13;
      7'h19:   decode = 5'h14;
      7'h12:   decode = 5'h15;
      7'h02:   decode = 5'h16;
      7'h78:   decode = 5'h17;
      7'h00:   decode = 5'h18;
      7'h10:   decode = 5'h19;
      7'h08:   decode = 5'h1A;
      7'h03:   decode = 5'h1B;
      7'h46:   decode = 5'h1C;
      7'h21:   decode = 5'h1D;
      7'h06:   decode = 5'h1E;
      7'h0E:   decode = 5'h1F;
      default: decode = 5'h00;
    endcase
  endfunction

  logic [6:0]          seg_meta_q, seg_s_q;
  logic [DIGITS-1:0]   an_meta_q, an_s_q;
  logic [DIGITS+6:0]   prev_q;
  logic [CW-1:0]       cnt_q, cnt_d;
  state_t              state_q, state_d;
  logic [4*DIGITS-1:0] value_q, value_d;
  logic [DIGITS-1:0]   digit_valid_q, digit_valid_d;
  logic                update_q, update_d;
  logic                err_q, err_d;
  logic [2:0]          err_digit_q, err_digit_d;

  logic [DIGITS-1:0]   an_low;
  logic                one_hot;
  logic                changed;
  logic                capture;
  logic [4:0]          dec;

  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    an_low        = ~an_s_q;
    one_hot       = (an_low != '0) && ((an_low & (an_low - DIGITS'(1))) == '0);
    changed       = ({an_s_q, seg_s_q} != prev_q);
    dec           = decode(seg_s_q);
    cnt_d         = changed ? '0 : ((cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1);
    state_d       = state_q;
    capture       = 1'b0;
    value_d       = value_q;
    digit_valid_d = digit_valid_q;
    update_d      = 1'b0;
    err_d         = 1'b0;
    err_digit_d   = err_digit_q;

    case (state_q)
      IDLE:     if (one_hot) state_d = SETTLE;
      SETTLE: begin
        if (!one_hot) begin
          state_d = IDLE;
        end else if (!changed && cnt_d == CNT_MAX) begin
          state_d = CAPTURED;
          capture = 1'b1;
        end
      end
      CAPTURED: if (changed) state_d = one_hot ? SETTLE : IDLE;
      default:  state_d = IDLE;
    endcase

    // an_s is one-hot-low whenever capture is set, so at most one digit matches.
    if (capture) begin
      for (int i = 0; i < DIGITS; i++) begin
        if (!an_s_q[i]) begin
          if (dec[4]) begin
            value_d[4*i +: 4] = dec[3:0];
            digit_valid_d[i]  = 1'b1;
            update_d          = 1'b1;
          end else begin
            digit_valid_d[i] = 1'b0;
            if (seg_s_q != 7'h7F) begin
              err_d       = 1'b1;
              err_digit_d = 3'(i);
            end
          end
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seg_meta_q    <= '1;
      seg_s_q       <= '1;
      an_meta_q     <= '1;
      an_s_q        <= '1;
      prev_q        <= '1;
      cnt_q         <= '0;
      state_q       <= IDLE;
      value_q       <= '0;
      digit_valid_q <= '0;
      update_q      <= 1'b0;
      err_q         <= 1'b0;
      err_digit_q   <= '0;
    end else begin
      seg_meta_q    <= seg_in;
      seg_s_q       <= seg_meta_q;
      an_meta_q     <= an_in;
      an_s_q        <= an_meta_q;
      prev_q        <= {an_s_q, seg_s_q};
      cnt_q         <= cnt_d;
      state_q       <= state_d;
      value_q       <= value_d;
      digit_valid_q <= digit_valid_d;
      update_q      <= update_d;
      err_q         <= err_d;
      err_digit_q   <= err_digit_d;
    end
  end

  assign value       = value_q;
  assign digit_valid = digit_valid_q;
  assign update      = update_q;
  assign err         = err_q;
  assign err_digit   = err_digit_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Scoreboard bench for seg_scan_decoder: stimulus queues expected pulses,
// a negedge monitor pops and compares every update/err pulse it sees.
module tb_seg_scan_decoder;

  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  seg_in;
  logic [3:0]  an_in;
  logic [15:0] value;
  logic [3:0]  digit_valid;
  logic        update;
  logic        err;
  logic [2:0]  err_digit;

  typedef struct {
    bit          is_err;
    int          due;
    logic [15:0] val;
    logic [3:0]  dv;
    logic [2:0]  ed;
  } ev_t;

  ev_t q[$];
  int  cyc = 0;
  int  n_checks = 0;
  int  n_fail = 0;

  localparam int NONE = 0, UPD = 1, ERR = 2;

  seg_scan_decoder #(.DIGITS(4), .STABLE_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .seg_in(seg_in), .an_in(an_in),
    .value(value), .digit_valid(digit_valid), .update(update),
    .err(err), .err_digit(err_digit)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Called at a negedge: apply inputs, optionally queue the expected pulse,
  // then hold for `hold` rising edges. Capture lands 6 edges after the drive.
  task automatic drive(input logic [3:0] an, input logic [6:0] seg, input int hold,
                       input int kind, input logic [15:0] val, input logic [3:0] dv,
                       input logic [2:0] ed);
    ev_t e;
    an_in  = an;
    seg_in = seg;
    if (kind != NONE) begin
      e.is_err = (kind == ERR);
      e.due    = cyc + 6;
      e.val    = val;
      e.dv     = dv;
      e.ed     = ed;
      q.push_back(e);
    end
    repeat (hold) @(negedge clk);
  endtask

  // Monitor: every pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    if (update || err) begin
      if (q.size() == 0) begin
        check("unexpected_pulse", {30'b0, update, err}, 32'h0);
      end else begin
        ev_t e;
        e = q.pop_front();
        check("pulse_exclusive", {31'b0, update & err}, 32'h0);
        check("pulse_is_err", {31'b0, err}, {31'b0, e.is_err});
        check("pulse_cycle", cyc, e.due);
        check("pulse_value", {16'b0, value}, {16'b0, e.val});
        check("pulse_digit_valid", {28'b0, digit_valid}, {28'b0, e.dv});
        check("pulse_err_digit", {29'b0, err_digit}, {29'b0, e.ed});
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    reset  = 1'b1;
    an_in  = 4'hF;
    seg_in = 7'h7F;
    repeat (3) @(negedge clk);
    check("rst_value", {16'b0, value}, 32'h0);
    check("rst_digit_valid", {28'b0, digit_valid}, 32'h0);
    check("rst_update", {31'b0, update}, 32'h0);
    check("rst_err", {31'b0, err}, 32'h0);
    check("rst_err_digit", {29'b0, err_digit}, 32'h0);
    reset = 1'b0;

    // Idle bus: no capture.
    drive(4'hF, 7'h7F, 10, NONE, '0, '0, '0);

    // Single digit 3 on digit 0, held 10 cycles: one pulse only.
    drive(4'hE, 7'h30, 10, UPD, 16'h0003, 4'b0001, 3'd0);

    // Full scan: 5, C, F, 1.
    drive(4'hE, 7'h12, 8, UPD, 16'h0005, 4'b0001, 3'd0);
    drive(4'hD, 7'h46, 8, UPD, 16'h00C5, 4'b0011, 3'd0);
    drive(4'hB, 7'h0E, 8, UPD, 16'h0FC5, 4'b0111, 3'd0);
    drive(4'h7, 7'h79, 8, UPD, 16'h1FC5, 4'b1111, 3'd0);
    check("scan_value", {16'b0, value}, 32'h1FC5);

    // Glitch rejection on digit 1, then settle on 2.
    for (int i = 0; i < 10; i++)
      drive(4'hD, (i % 2 == 0) ? 7'h24 : 7'h30, 2, NONE, '0, '0, '0);
    drive(4'hD, 7'h24, 10, UPD, 16'h1F25, 4'b1111, 3'd0);

    // Blank on digit 2 clears its valid silently; bad pattern on digit 3 errs.
    drive(4'hB, 7'h7F, 10, NONE, '0, '0, '0);
    check("blank_digit_valid", {28'b0, digit_valid}, 32'hB);
    check("blank_value", {16'b0, value}, 32'h1F25);
    drive(4'h7, 7'h55, 10, ERR, 16'h1F25, 4'b0011, 3'd3);

    // Two digits selected: no capture.
    drive(4'hC, 7'h00, 10, NONE, '0, '0, '0);
    check("multi_digit_valid", {28'b0, digit_valid}, 32'h3);

    // Reset three cycles into settling, then full settle after release.
    drive(4'hE, 7'h00, 3, NONE, '0, '0, '0);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("mid_rst_value", {16'b0, value}, 32'h0);
    check("mid_rst_digit_valid", {28'b0, digit_valid}, 32'h0);
    check("mid_rst_err_digit", {29'b0, err_digit}, 32'h0);
    reset = 1'b0;
    drive(4'hE, 7'h00, 14, UPD, 16'h0008, 4'b0001, 3'd0);

    check("final_value", {16'b0, value}, 32'h0008);
    check("pending_events", q.size(), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
